// File: rtl/bin2bcd_seg_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with
// active-low 7-segment drive, optional leading-zero blanking and overflow flag.
module bin2bcd_seg_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    input  logic                  in_blank_lz,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [7*DIGITS-1:0]   out_seg,
    output logic                  out_ovf
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e                state_q, state_d;
    logic [BIN_W-1:0]      bin_q, bin_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  ovf_q, ovf_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  blank_q, blank_d;
    logic [4*DIGITS-1:0]   out_bcd_q, out_bcd_d;
    logic [7*DIGITS-1:0]   out_seg_q, out_seg_d;
    logic                  out_ovf_q, out_ovf_d;

    logic [4*DIGITS-1:0]   bcd_adj;
    logic [4*DIGITS-1:0]   bcd_shift;
    logic                  carry;
    logic [7*DIGITS-1:0]   seg_next;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // The bit leaving the top digit carries weight 10^DIGITS, so it marks overflow.
    assign carry     = bcd_adj[4*DIGITS-1];
    assign bcd_shift = {bcd_adj[4*DIGITS-2:0], bin_q[BIN_W-1]};

    always_comb begin
        logic       seen;
        logic [3:0] d;
        seen     = 1'b0;
        seg_next = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = bcd_shift[4*i +: 4];
            if (d != 4'd0 || i == 0) seen = 1'b1;
            seg_next[7*i +: 7] = (blank_q && !seen) ? 7'h7F : seg7(d);
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        blank_d   = blank_q;
        out_bcd_d = out_bcd_q;
        out_seg_d = out_seg_q;
        out_ovf_d = out_ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = in_bin;
                    blank_d = in_blank_lz;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bin_d = bin_q << 1;
                bcd_d = bcd_shift;
                ovf_d = ovf_q | carry;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d   = DONE;
                    out_bcd_d = bcd_shift;
                    out_seg_d = seg_next;
                    out_ovf_d = ovf_q | carry;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            blank_q   <= 1'b0;
            out_bcd_q <= '0;
            out_seg_q <= '1;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            blank_q   <= blank_d;
            out_bcd_q <= out_bcd_d;
            out_seg_q <= out_seg_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_bcd   = out_bcd_q;
    assign out_seg   = out_seg_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_bin2bcd_seg_seq.sv
// Bench for bin2bcd_seg_seq: default 16b/5-digit instance plus an 8b/2-digit
// instance for overflow; fixed vectors, handshake/reset sequences, random model checks.
module tb_bin2bcd_seg_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        iv0, ir0, bl0, ov0, or0, ovf0;
    logic [15:0] ib0;
    logic [19:0] bcd0;
    logic [34:0] seg0;

    logic        iv1, ir1, bl1, ov1, or1, ovf1;
    logic [7:0]  ib1;
    logic [7:0]  bcd1;
    logic [13:0] seg1;

    bin2bcd_seg_seq #(.BIN_W(16), .DIGITS(5)) dut0 (
        .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .in_bin(ib0),
        .in_blank_lz(bl0), .out_valid(ov0), .out_ready(or0), .out_bcd(bcd0),
        .out_seg(seg0), .out_ovf(ovf0));

    bin2bcd_seg_seq #(.BIN_W(8), .DIGITS(2)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_bin(ib1),
        .in_blank_lz(bl1), .out_valid(ov1), .out_ready(or1), .out_bcd(bcd1),
        .out_seg(seg1), .out_ovf(ovf1));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: decimal digits by repeated division, segment lookup table.
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [69:0] model_bcd(input longint unsigned v, input int nd);
        logic [69:0] r = '0;
        longint unsigned x = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [69:0] model_seg(input longint unsigned v, input int nd, input logic bl);
        logic [69:0] r = '0;
        int dig [10];
        int top = 0;
        longint unsigned x = v;
        for (int i = 0; i < nd; i++) begin
            dig[i] = int'(x % 10);
            x = x / 10;
            if (dig[i] != 0) top = i;
        end
        for (int i = 0; i < nd; i++)
            r[7*i +: 7] = (bl && i > top) ? 7'h7F : seg_tab[dig[i]];
        return r;
    endfunction

    function automatic logic model_ovf(input longint unsigned v, input int nd);
        longint unsigned lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        return v > lim - 1;
    endfunction

    task automatic run0(input logic [15:0] b, input logic bl, output int lat);
        int n = 0;
        @(negedge clk);
        while (!ir0 && n < 100) begin @(negedge clk); n++; end
        check("dut0_in_ready_wait", ir0, 1);
        ib0 = b; bl0 = bl; iv0 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0; ib0 = 16'($urandom); bl0 = 1'($urandom);
        lat = 1;
        while (!ov0 && lat < 200) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic run1(input logic [7:0] b, input logic bl, output int lat);
        int n = 0;
        @(negedge clk);
        while (!ir1 && n < 100) begin @(negedge clk); n++; end
        check("dut1_in_ready_wait", ir1, 1);
        ib1 = b; bl1 = bl; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0; ib1 = 8'($urandom); bl1 = 1'($urandom);
        lat = 1;
        while (!ov1 && lat < 200) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic after_done0(input string tag);
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, ov0, 0);
        check({tag, "_idle_ready"}, ir0, 1);
    endtask

    typedef struct {
        logic [15:0] bin;
        logic        blank;
        logic [19:0] bcd;
        logic [34:0] seg;
    } vec0_t;

    typedef struct {
        logic [7:0]  bin;
        logic        blank;
        logic [7:0]  bcd;
        logic [13:0] seg;
        logic        ovf;
    } vec1_t;

    vec0_t tab0 [7];
    vec1_t tab1 [6];

    initial begin
        int lat;
        logic seen_valid;
        logic [15:0] v;
        logic [7:0] w;
        logic b;

        tab0[0] = '{16'd65535, 1'b0, 20'h65535, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12}};
        tab0[1] = '{16'd0,     1'b1, 20'h00000, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        tab0[2] = '{16'd0,     1'b0, 20'h00000, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        tab0[3] = '{16'd1234,  1'b1, 20'h01234, {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}};
        tab0[4] = '{16'd1004,  1'b1, 20'h01004, {7'h7F, 7'h79, 7'h40, 7'h40, 7'h19}};
        tab0[5] = '{16'd10000, 1'b1, 20'h10000, {7'h79, 7'h40, 7'h40, 7'h40, 7'h40}};
        tab0[6] = '{16'd42,    1'b0, 20'h00042, {7'h40, 7'h40, 7'h40, 7'h19, 7'h24}};

        tab1[0] = '{8'd255, 1'b0, 8'h55, {7'h12, 7'h12}, 1'b1};
        tab1[1] = '{8'd99,  1'b0, 8'h99, {7'h10, 7'h10}, 1'b0};
        tab1[2] = '{8'd100, 1'b1, 8'h00, {7'h7F, 7'h40}, 1'b1};
        tab1[3] = '{8'd5,   1'b1, 8'h05, {7'h7F, 7'h12}, 1'b0};
        tab1[4] = '{8'd10,  1'b1, 8'h10, {7'h79, 7'h40}, 1'b0};
        tab1[5] = '{8'd203, 1'b1, 8'h03, {7'h7F, 7'h30}, 1'b1};

        reset = 1'b1;
        iv0 = 0; ib0 = '0; bl0 = 0; or0 = 1;
        iv1 = 0; ib1 = '0; bl1 = 0; or1 = 1;
        #12;
        check("rst_in_ready", ir0, 1);
        check("rst_out_valid", ov0, 0);
        check("rst_bcd", bcd0, 0);
        check("rst_seg", seg0, {35{1'b1}});
        check("rst_ovf", ovf0, 0);
        check("rst1_seg", seg1, {14{1'b1}});
        @(negedge clk); reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run0(tab0[i].bin, tab0[i].blank, lat);
            check($sformatf("t0_lat[%0d]", i), lat, 17);
            check($sformatf("t0_bcd[%0d]", i), bcd0, tab0[i].bcd);
            check($sformatf("t0_seg[%0d]", i), seg0, tab0[i].seg);
            check($sformatf("t0_ovf[%0d]", i), ovf0, 0);
            after_done0($sformatf("t0[%0d]", i));
        end

        for (int i = 0; i < 6; i++) begin
            run1(tab1[i].bin, tab1[i].blank, lat);
            check($sformatf("t1_lat[%0d]", i), lat, 9);
            check($sformatf("t1_bcd[%0d]", i), bcd1, tab1[i].bcd);
            check($sformatf("t1_seg[%0d]", i), seg1, tab1[i].seg);
            check($sformatf("t1_ovf[%0d]", i), ovf1, tab1[i].ovf);
        end

        // Backpressure: hold DONE for 10 clocks while offering a new word.
        or0 = 1'b0;
        run0(16'd31415, 1'b0, lat);
        check("bp_lat", lat, 17);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            iv0 = 1'b1; ib0 = 16'($urandom); bl0 = 1'($urandom);
            @(posedge clk); #1;
            check($sformatf("bp_valid[%0d]", i), ov0, 1);
            check($sformatf("bp_ready[%0d]", i), ir0, 0);
            check($sformatf("bp_bcd[%0d]", i), bcd0, 20'h31415);
            check($sformatf("bp_seg[%0d]", i), seg0, {7'h30, 7'h79, 7'h19, 7'h79, 7'h12});
        end
        @(negedge clk);
        iv0 = 1'b0; or0 = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", ov0, 0);
        check("bp_release_idle", ir0, 1);
        run0(16'd42, 1'b0, lat);
        check("bp_next_lat", lat, 17);
        check("bp_next_bcd", bcd0, 20'h00042);
        after_done0("bp_next");

        // Reset five clocks into SHIFT discards the conversion.
        @(negedge clk);
        ib0 = 16'd54321; bl0 = 1'b0; iv0 = 1'b1;
        @(posedge clk); #1;
        iv0 = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_ready", ir0, 1);
        check("mid_rst_valid", ov0, 0);
        check("mid_rst_bcd", bcd0, 0);
        check("mid_rst_seg", seg0, {35{1'b1}});
        check("mid_rst_ovf", ovf0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (ov0) seen_valid = 1'b1;
        end
        check("mid_rst_no_valid", seen_valid, 0);
        run0(16'd7, 1'b0, lat);
        check("post_rst_lat", lat, 17);
        check("post_rst_bcd", bcd0, 20'h00007);
        check("post_rst_seg", seg0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h78});
        after_done0("post_rst");

        // Random words against the reference model.
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0:       v = 16'($urandom);
                1:       v = 16'($urandom_range(0, 99));
                default: v = 16'($urandom_range(0, 12000));
            endcase
            b = 1'($urandom);
            run0(v, b, lat);
            check($sformatf("r0_lat[%0d]", i), lat, 17);
            check($sformatf("r0_bcd[%0d] v=%0d", i, v), bcd0, model_bcd(v, 5));
            check($sformatf("r0_seg[%0d] v=%0d", i, v), seg0, model_seg(v, 5, b));
            check($sformatf("r0_ovf[%0d]", i), ovf0, model_ovf(v, 5));
        end
        for (int i = 0; i < 20; i++) begin
            w = 8'($urandom);
            b = 1'($urandom);
            run1(w, b, lat);
            check($sformatf("r1_lat[%0d]", i), lat, 9);
            check($sformatf("r1_bcd[%0d] v=%0d", i, w), bcd1, model_bcd(w, 2));
            check($sformatf("r1_seg[%0d] v=%0d", i, w), seg1, model_seg(w, 2, b));
            check($sformatf("r1_ovf[%0d] v=%0d", i, w), ovf1, model_ovf(w, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
